key_event_queue: RTL and testbench

Debounces the 5-bit keycode produced by the 4x4 keypad scanner and turns each new key press into one event in a small FIFO. The CPU reads the FIFO through a single memory-mapped word. It sits directly downstream of the keypad scanner, in the same clock domain, and replaces the raw level-valued keyboard word with a queued, pop-on-read interface. Keycode 0 means "no key"; codes 1–31 identify keys.

---
 rtl/key_event_queue.sv | 97 +++++++++
 tb/tb_key_event_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/key_event_queue.sv
// Keypad event queue: debounces the scanner keycode and queues one event per new press.
// The CPU pops events through a single status/data word.
module key_event_queue #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [4:0]                 keycode,
  input  logic                       popKey,
  output logic [15:0]                keyData,
  output logic [$clog2(DEPTH):0]     keyCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES);
  localparam logic [AW:0]   DepthW = (AW + 1)'(DEPTH);

  logic [4:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    stable_q, stable_d;
  logic          push_req_q, push_req_d;

  logic [AW:0]   wp_q, wp_d;
  logic [AW:0]   rp_q, rp_d;
  logic          overflow_q, overflow_d;
  logic [4:0]    mem [DEPTH];

  logic          empty, full, do_pop, do_push;
  logic [AW:0]   count;

  // Debounce: acceptance uses the post-edge count so stable updates on the Nth sample.
  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    if (keycode != cand_q) begin
      cand_d = keycode;
      cnt_d  = CW'(1);
    end else if (cnt_q < CntMax) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_d == CntMax && cand_d != stable_q) begin
      stable_d = cand_d;
    end
    push_req_d = (stable_d != stable_q) && (stable_d != 5'd0);
  end

  assign count   = wp_q - rp_q;
  assign empty   = (wp_q == rp_q);
  assign full    = (count == DepthW);
  assign do_pop  = popKey && !empty;
  // A pop on the same edge frees the slot, so a push into a full queue still lands.
  assign do_push = push_req_q && (!full || do_pop);

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    overflow_d = overflow_q;
    if (do_push) wp_d = wp_q + (AW + 1)'(1);
    if (do_pop) begin
      rp_d       = rp_q + (AW + 1)'(1);
      overflow_d = 1'b0;
    end else if (push_req_q && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cand_q     <= '0;
      cnt_q      <= '0;
      stable_q   <= '0;
      push_req_q <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      push_req_q <= push_req_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wp_q[AW-1:0]] <= stable_q;
  end

  assign keyData  = {!empty, overflow_q, 9'd0, empty ? 5'd0 : mem[rp_q[AW-1:0]]};
  assign keyCount = count;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with DEPTH=4, DEBOUNCE_CYCLES=4.
module tb_key_event_queue;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [4:0]  keycode = 5'd0;
  logic        popKey = 1'b0;
  logic [15:0] keyData;
  logic [2:0]  keyCount;

  int n_cmp = 0;
  int n_bad = 0;

  key_event_queue #(.DEPTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .keycode(keycode),
    .popKey(popKey),
    .keyData(keyData),
    .keyCount(keyCount)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [4:0] code, input int n);
    keycode = code;
    tick(n);
  endtask

  task automatic pop1();
    popKey = 1'b1;
    tick(1);
    popKey = 1'b0;
  endtask

  initial begin
    // Reset state with a key already held
    keycode = 5'd5;
    #2 RST = 1'b1;
    tick(2);
    check("rst_data", keyData, 16'h0000);
    check("rst_count", {13'd0, keyCount}, 16'd0);
    RST = 1'b0;
    tick(4);
    check("press_edge4", keyData, 16'h0000);
    tick(1);
    check("press_edge5", keyData, 16'h8005);
    check("press_count", {13'd0, keyCount}, 16'd1);
    hold(5'd0, 5);
    check("hold_once", {13'd0, keyCount}, 16'd1);
    pop1();
    check("pop_to_empty", keyData, 16'h0000);

    // Glitch and release
    hold(5'd7, 3);
    hold(5'd0, 5);
    check("glitch_count", {13'd0, keyCount}, 16'd0);
    hold(5'd7, 10);
    hold(5'd0, 5);
    hold(5'd7, 10);
    check("repress_count", {13'd0, keyCount}, 16'd2);
    check("repress_head", keyData, 16'h8007);
    pop1();
    check("repress_second", keyData, 16'h8007);
    pop1();
    check("repress_empty", keyData, 16'h0000);
    hold(5'd0, 5);

    // Direct code change
    hold(5'd3, 5);
    hold(5'd9, 5);
    check("chg_count", {13'd0, keyCount}, 16'd2);
    check("chg_head", keyData, 16'h8003);
    pop1();
    check("chg_pop1", keyData, 16'h8009);
    pop1();
    check("chg_pop2", keyData, 16'h0000);
    hold(5'd0, 5);

    // Overflow
    hold(5'd1, 5);
    hold(5'd2, 5);
    hold(5'd3, 5);
    hold(5'd4, 5);
    hold(5'd6, 5);
    check("ovf_count", {13'd0, keyCount}, 16'd4);
    check("ovf_data", keyData, 16'hC001);
    pop1();
    check("ovf_pop", keyData, 16'h8002);
    check("ovf_pop_count", {13'd0, keyCount}, 16'd3);
    pop1();
    pop1();
    pop1();
    check("ovf_drain", {13'd0, keyCount}, 16'd0);
    hold(5'd0, 5);

    // Push and pop on the same edge while full
    hold(5'd1, 5);
    hold(5'd2, 5);
    hold(5'd3, 5);
    hold(5'd4, 5);
    check("full_head", keyData, 16'h8001);
    hold(5'd5, 4);
    pop1();
    check("full_pp_count", {13'd0, keyCount}, 16'd4);
    check("full_pp_data", keyData, 16'h8002);
    pop1();
    check("full_order3", keyData, 16'h8003);
    pop1();
    check("full_order4", keyData, 16'h8004);
    pop1();
    check("full_order5", keyData, 16'h8005);
    pop1();
    check("full_order_empty", keyData, 16'h0000);
    hold(5'd0, 5);

    // Push and pop on the same edge while empty, then pop while empty
    hold(5'd8, 4);
    pop1();
    check("empty_pp_count", {13'd0, keyCount}, 16'd1);
    check("empty_pp_data", keyData, 16'h8008);
    pop1();
    check("empty_pop", keyData, 16'h0000);
    pop1();
    check("idle_pop_data", keyData, 16'h0000);
    check("idle_pop_count", {13'd0, keyCount}, 16'd0);
    hold(5'd0, 5);

    // Wrap-around: ten push/pop pairs
    for (int i = 1; i <= 10; i++) begin
      hold(5'(i), 5);
      check($sformatf("wrap_data%0d", i), keyData, 16'h8000 | 16'(i));
      pop1();
      check($sformatf("wrap_cnt%0d", i), {13'd0, keyCount}, 16'd0);
    end
    hold(5'd0, 5);

    // Mid-operation reset is asynchronous
    hold(5'd10, 5);
    hold(5'd11, 5);
    hold(5'd12, 5);
    check("mid_count", {13'd0, keyCount}, 16'd3);
    RST = 1'b1;
    #1;
    check("mid_rst_data", keyData, 16'h0000);
    check("mid_rst_count", {13'd0, keyCount}, 16'd0);
    tick(1);
    RST = 1'b0;
    tick(5);
    check("post_rst_repush", keyData, 16'h800C);
    check("post_rst_count", {13'd0, keyCount}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
